// File: rtl/core_sync_pkg.sv
// Shared types and constants for the per-core pause/resume and stall port.
package core_sync_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, PAUSED} state_e;

  localparam int unsigned REQ_W        = 3;
  localparam int unsigned REQ_VALID    = 2;
  localparam int unsigned REQ_STATE    = 1;
  localparam int unsigned REQ_TARGET   = 0;
  localparam int unsigned CORE1        = 0;
  localparam int unsigned CORE2        = 1;
  localparam int unsigned STALL_PAUSED = 6;

  typedef struct packed {
    logic resume;
    logic target;
  } cmd_t;

  // Request-bus encoding of a latched command.
  function automatic logic [REQ_W-1:0] req_pack(cmd_t c);
    logic [REQ_W-1:0] r;
    r             = '0;
    r[REQ_VALID]  = 1'b1;
    r[REQ_STATE]  = c.resume;
    r[REQ_TARGET] = c.target;
    return r;
  endfunction

endpackage

// File: rtl/core_sync_port_if.sv
// Command handshake and top-level request/state bus of one core sync port.
interface core_sync_port_if;
  import core_sync_pkg::*;

  logic             cmd_valid;
  logic             cmd_resume;
  logic             cmd_target;
  logic             cmd_ready;
  logic [REQ_W-1:0] pause_resume_o;
  logic [1:0]       run_state_i;

  modport master (
    output cmd_valid, cmd_resume, cmd_target, run_state_i,
    input  cmd_ready, pause_resume_o
  );

  modport slave (
    input  cmd_valid, cmd_resume, cmd_target, run_state_i,
    output cmd_ready, pause_resume_o
  );

endinterface

// File: rtl/core_sync_port_stall_counter.sv
// Down-counter that reloads to max(remaining-1, load value); nz_o flags cycles left.
module core_sync_port_stall_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         nz_o
);

  logic [W-1:0] cnt_q, cnt_d, cnt_dec;

  always_comb begin
    cnt_dec = (cnt_q != '0) ? cnt_q - W'(1) : '0;
    cnt_d   = cnt_dec;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (load_i && (load_val_i > cnt_dec)) begin
      cnt_d = load_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign nz_o = (cnt_q != '0);

endmodule

// File: rtl/core_sync_port.sv
// Per-core pause/resume request issuer and pipeline stall generator.
// Optional CORE_SYNC_STATS_EN adds stall-cycle and command counters.
module core_sync_port
  import core_sync_pkg::*;
#(
  parameter int unsigned CORE_ID     = 0,
  parameter int unsigned STALL_W     = 3,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  core_sync_port_if.slave    bus,
  input  logic [STALL_W-1:0] stall_num_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               err_timeout_o
`ifdef CORE_SYNC_STATS_EN
  ,
  output logic [15:0]        stall_cycles_o,
  output logic [7:0]         cmd_count_o
`endif
);

  localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic        SELF  = CORE_ID[0];

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  logic   err_q, err_d;
  logic   settled_q, settled_d;
  logic   self_run, tgt_match;
  logic   ack_load, ack_hold, ack_nz;
  logic   stall_nz, stall_c;

  assign self_run  = bus.run_state_i[SELF];
  assign tgt_match = (bus.run_state_i[cmd_q.target] == cmd_q.resume);

  // Next state; the FSM freezes while another core holds us paused.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    err_d     = err_q;
    ack_load  = 1'b0;
    ack_hold  = 1'b0;
    settled_d = (state_q == PAUSED);
    if ((state_q != PAUSED) && !self_run) begin
      ack_hold = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_d.resume = bus.cmd_resume;
            cmd_d.target = bus.cmd_target;
            state_d      = ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_q.target != SELF) begin
            state_d  = WAIT_ACK;
            ack_load = 1'b1;
          end else if (cmd_q.resume) begin
            state_d = IDLE;
          end else begin
            state_d = PAUSED;
          end
        end
        WAIT_ACK: begin
          if (tgt_match) begin
            state_d = IDLE;
          end else if (!ack_nz) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        PAUSED: begin
          // First PAUSED cycle ignored: the top's state register lags ISSUE.
          if (settled_q && self_run) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      err_q     <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      err_q     <= err_d;
      settled_q <= settled_d;
    end
  end

  // Ack window: ACK_TIMEOUT WAIT_ACK cycles, last one when the count reads zero.
  core_sync_port_stall_counter #(.W(ACK_W)) u_ack_cnt (
    .clk        (clk),
    .reset      (reset),
    .hold_i     (ack_hold),
    .load_i     (ack_load),
    .load_val_i (ACK_W'(ACK_TIMEOUT - 1)),
    .nz_o       (ack_nz)
  );

  core_sync_port_stall_counter #(.W(STALL_W)) u_stall_cnt (
    .clk        (clk),
    .reset      (reset),
    .hold_i     (1'b0),
    .load_i     (stall_num_i != '0),
    .load_val_i (stall_num_i - STALL_W'(1)),
    .nz_o       (stall_nz)
  );

  assign stall_c = (stall_num_i != '0) | stall_nz | (state_q == PAUSED) | !self_run;

  assign stall_o            = stall_c;
  assign busy_o             = (state_q == ISSUE) || (state_q == WAIT_ACK);
  assign err_timeout_o      = err_q;
  assign bus.cmd_ready      = (state_q == IDLE) && self_run;
  assign bus.pause_resume_o = (state_q == ISSUE) ? req_pack(cmd_q) : '0;

`ifdef CORE_SYNC_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [7:0]  cmd_count_q, cmd_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    cmd_count_d    = cmd_count_q;
    if (stall_c && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 16'd1;
    if (state_q == ISSUE)                  cmd_count_d    = cmd_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      cmd_count_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      cmd_count_q    <= cmd_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign cmd_count_o    = cmd_count_q;
`endif

endmodule

// File: tb/tb_core_sync_port.sv
// Self-checking bench for core_sync_port (CORE_ID = 0) with a cycle-timeline model of the top.
module tb_core_sync_port;
  import core_sync_pkg::*;

  localparam int unsigned STALL_W     = 3;
  localparam int unsigned ACK_TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               reset;
  logic [STALL_W-1:0] stall_num;
  logic               stall_o, busy_o, err_o;
`ifdef CORE_SYNC_STATS_EN
  logic [15:0]        stall_cycles;
  logic [7:0]         cmd_count;
`endif

  int checks = 0;
  int errors = 0;

  core_sync_port_if bif ();

  core_sync_port #(
    .CORE_ID     (CORE1),
    .STALL_W     (STALL_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bif.slave),
    .stall_num_i    (stall_num),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .err_timeout_o  (err_o)
`ifdef CORE_SYNC_STATS_EN
    ,
    .stall_cycles_o (stall_cycles),
    .cmd_count_o    (cmd_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1;
    bif.cmd_valid = 1'b0; bif.cmd_resume = 1'b0; bif.cmd_target = 1'b0;
    bif.run_state_i = 2'b11;
    stall_num = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bif.pause_resume_o !== 3'b000) begin errors++; $display("FAIL reset_bus: got %b expected 000", bif.pause_resume_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bif.cmd_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Stall model: a stall of n at cycle c keeps the core frozen up to cycle c+n-1.
  task automatic test_stall(input int n_random);
    int dir [14] = '{3, 0, 0, 0, 0, 6, 2, 0, 0, 0, 0, 0, 0, 0};
    int end_c = 0;
    int n;
    logic exp;
    for (int c = 0; c < 14 + n_random; c++) begin
      if (c < 14) n = dir[c];
      else        n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      @(negedge clk);
      stall_num = STALL_W'(n);
      #1;
      if ((n != 0) && (c + n > end_c)) end_c = c + n;
      exp = (c < end_c);
      checks++; if (stall_o !== exp) begin errors++; $display("FAIL stall c=%0d n=%0d: got %b expected %b", c, n, stall_o, exp); end
    end
    @(negedge clk);
    stall_num = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_paused_by_other();
    @(negedge clk);
    bif.run_state_i = 2'b10;
    bif.cmd_valid = 1'b1; bif.cmd_resume = 1'b1; bif.cmd_target = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL other_stall: got %b expected 1", stall_o); end
    checks++; if (bif.cmd_ready !== 1'b0) begin errors++; $display("FAIL other_ready: got %b expected 0", bif.cmd_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL other_busy c=%0d: got %b expected 0", c, busy_o); end
      checks++; if (bif.pause_resume_o !== 3'b000) begin errors++; $display("FAIL other_bus c=%0d: got %b expected 000", c, bif.pause_resume_o); end
    end
    @(negedge clk);
    bif.cmd_valid = 1'b0;
    bif.run_state_i = 2'b11;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL other_release_stall: got %b expected 0", stall_o); end
    checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL other_release_ready: got %b expected 1", bif.cmd_ready); end
  endtask

  // Each command: ISSUE at cycle 1; the top answers at cycle 1+lat.
  // Other-core: acked in WAIT_ACK cycle j (1-based) -> idle at j+2; no ack within ACK_TIMEOUT -> error.
  // Self-pause: top clears our bit at cycle 2 and sets it at 1+lat (lat 0 = never clears).
  task automatic test_commands(input int n_random);
    int d_res [7] = '{0, 0, 0, 1, 1, 0, 1};
    int d_tgt [7] = '{1, 0, 0, 1, 1, 1, 0};
    int d_lat [7] = '{3, 5, 0, 15, 4, 16, 0};
    logic [1:0] rs0, rs;
    logic err_acc = 1'b0;
    int res, tgt, lat, done, c_last, j;
    logic other, self_pause, timeout;
    logic [2:0] e_bus;
    logic e_busy, e_stall, e_ready, e_err;
    rs = 2'b11;
    for (int k = 0; k < 7 + n_random; k++) begin
      if (k < 7) begin
        res = d_res[k]; tgt = d_tgt[k]; lat = d_lat[k];
      end else begin
        res = int'($urandom_range(0, 1));
        tgt = int'($urandom_range(0, 1));
        if (tgt != 0)    lat = int'($urandom_range(1, 20));
        else if (res == 0) lat = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 8));
        else             lat = 0;
      end
      rs0        = rs;
      other      = (tgt != 0);
      self_pause = !other && (res == 0);
      timeout    = 1'b0;
      if (other) begin
        j = (rs0[tgt] == res[0]) ? 1 : lat;
        if (j <= ACK_TIMEOUT) done = j + 2;
        else begin done = ACK_TIMEOUT + 2; timeout = 1'b1; end
        c_last = ((done > 1 + lat) ? done : 1 + lat) + 1;
      end else if (self_pause) begin
        done   = (lat == 0) ? 4 : lat + 2;
        c_last = done + 1;
      end else begin
        done   = 2;
        c_last = done + 1;
      end
      for (int c = 0; c <= c_last; c++) begin
        @(negedge clk);
        bif.cmd_valid  = (c == 0);
        bif.cmd_resume = res[0];
        bif.cmd_target = tgt[0];
        rs = rs0;
        if (other && (c >= 1 + lat)) rs[tgt] = res[0];
        if (self_pause && (lat != 0) && (c >= 2) && (c < 1 + lat)) rs[0] = 1'b0;
        bif.run_state_i = rs;
        #1;
        e_bus   = (c == 1) ? {1'b1, res[0], tgt[0]} : 3'b000;
        e_busy  = other ? ((c >= 1) && (c < done)) : (c == 1);
        e_stall = self_pause && (c >= 2) && (c < done);
        e_ready = (c == 0) || (c >= done);
        e_err   = err_acc | (timeout && (c >= done));
        checks++; if (bif.pause_resume_o !== e_bus) begin errors++; $display("FAIL cmd%0d_bus c=%0d: got %b expected %b", k, c, bif.pause_resume_o, e_bus); end
        checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL cmd%0d_busy c=%0d: got %b expected %b", k, c, busy_o, e_busy); end
        checks++; if (stall_o !== e_stall) begin errors++; $display("FAIL cmd%0d_stall c=%0d: got %b expected %b", k, c, stall_o, e_stall); end
        checks++; if (bif.cmd_ready !== e_ready) begin errors++; $display("FAIL cmd%0d_ready c=%0d: got %b expected %b", k, c, bif.cmd_ready, e_ready); end
        checks++; if (err_o !== e_err) begin errors++; $display("FAIL cmd%0d_err c=%0d: got %b expected %b", k, c, err_o, e_err); end
      end
      err_acc = err_acc | timeout;
    end
  endtask

  // Resume core2 that never comes up: error raised after ACK_TIMEOUT WAIT_ACK cycles.
  task automatic test_timeout();
    logic e_busy, e_err;
    int done = ACK_TIMEOUT + 2;
    @(negedge clk);
    reset = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.run_state_i = 2'b01;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c <= done + 1; c++) begin
      @(negedge clk);
      bif.cmd_valid = (c == 0); bif.cmd_resume = 1'b1; bif.cmd_target = 1'b1;
      #1;
      e_busy = (c >= 1) && (c < done);
      e_err  = (c >= done);
      checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL timeout_busy c=%0d: got %b expected %b", c, busy_o, e_busy); end
      checks++; if (err_o !== e_err) begin errors++; $display("FAIL timeout_err c=%0d: got %b expected %b", c, err_o, e_err); end
      checks++; if (bif.cmd_ready !== ((c == 0) || e_err)) begin errors++; $display("FAIL timeout_ready c=%0d: got %b expected %b", c, bif.cmd_ready, ((c == 0) || e_err)); end
    end
  endtask

  task automatic test_reset_mid_cmd();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      bif.cmd_valid = (c == 0); bif.cmd_resume = 1'b1; bif.cmd_target = 1'b1;
      bif.run_state_i = 2'b01;
      reset = (c == 3);
      #1;
      if (c == 1) begin
        checks++; if (bif.pause_resume_o !== 3'b111) begin errors++; $display("FAIL midrst_issue_bus: got %b expected 111", bif.pause_resume_o); end
      end
      if ((c == 2) || (c == 3)) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midrst_wait_busy c=%0d: got %b expected 1", c, busy_o); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL midrst_sticky_err c=%0d: got %b expected 1", c, err_o); end
      end
      if (c >= 4) begin
        checks++; if (bif.pause_resume_o !== 3'b000) begin errors++; $display("FAIL midrst_bus c=%0d: got %b expected 000", c, bif.pause_resume_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy c=%0d: got %b expected 0", c, busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midrst_err c=%0d: got %b expected 0", c, err_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL midrst_stall c=%0d: got %b expected 0", c, stall_o); end
        checks++; if (bif.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready c=%0d: got %b expected 1", c, bif.cmd_ready); end
      end
    end
  endtask

`ifdef CORE_SYNC_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    reset = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.run_state_i = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL stats_reset_stall: got %0d expected 0", stall_cycles); end
    checks++; if (cmd_count !== 8'd0) begin errors++; $display("FAIL stats_reset_cmd: got %0d expected 0", cmd_count); end
    @(negedge clk);
    stall_num = STALL_W'(4);
    @(negedge clk);
    stall_num = '0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        bif.cmd_valid = (c == 0); bif.cmd_resume = 1'b1; bif.cmd_target = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (stall_cycles !== 16'd4) begin errors++; $display("FAIL stats_stall_cycles: got %0d expected 4", stall_cycles); end
    checks++; if (cmd_count !== 8'd2) begin errors++; $display("FAIL stats_cmd_count: got %0d expected 2", cmd_count); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bif.cmd_valid = 1'b0; bif.cmd_resume = 1'b0; bif.cmd_target = 1'b0;
    bif.run_state_i = 2'b11;
    stall_num = '0;
    test_reset();
    test_stall(80);
    test_paused_by_other();
    test_commands(25);
    test_timeout();
    test_reset_mid_cmd();
`ifdef CORE_SYNC_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
